// File: rtl/sdram_udp_tx_pkg.sv
// Shared types and constants for the SDRAM-to-UDP frame transmitter:
// FSM state encoding, packet header layout and packet sizing helper.
package sdram_udp_tx_pkg;

  localparam int DEF_H_PIXEL    = 800;
  localparam int DEF_V_PIXEL    = 480;
  localparam int DEF_PKT_PIXELS = 512;
  localparam int DEF_GAP_CYCLES = 64;
  localparam int DEF_FRAME_PIX  = DEF_H_PIXEL * DEF_V_PIXEL;

  localparam logic [15:0] HDR_TAG = 16'hA55A;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRELOAD   = 3'd1,
    ST_START     = 3'd2,
    ST_SEND      = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } tx_state_e;

  typedef struct packed {
    logic [15:0] tag;
    logic [15:0] pkt_idx;
  } hdr_word_t;

  function automatic logic [31:0] hdr_word(input logic [15:0] idx);
    hdr_word_t h;
    h.tag     = HDR_TAG;
    h.pkt_idx = idx;
    return h;
  endfunction

  // Pixels in the next packet: a full packet, or whatever is left of the frame.
  function automatic logic [10:0] pkt_len(input logic [19:0] pix_left, input logic [10:0] max_pix);
    if (pix_left < {9'd0, max_pix}) begin
      return pix_left[10:0];
    end else begin
      return max_pix;
    end
  endfunction

endpackage

// File: rtl/sdram_udp_tx_packer.sv
// Packs two consecutive 16-bit read-FIFO pixels into one 32-bit word.
// A fetch pulse at cycle N issues reads at N+1 and N+2; the word is valid from N+4.
module px_word_packer
  import sdram_udp_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_i,
  input  logic [15:0] rd_data_i,
  output logic        rd_en_o,
  output logic [31:0] word_o,
  output logic        valid_o
);

  logic        rd_en_q;
  logic        second_q;
  logic        dv_q;
  logic        dsel_q;
  logic        valid_q;
  logic [15:0] hi_q;
  logic [15:0] lo_q;

  // Read pulse pair, FIFO data capture one cycle behind each read, valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q  <= 1'b0;
      second_q <= 1'b0;
      dv_q     <= 1'b0;
      dsel_q   <= 1'b0;
      valid_q  <= 1'b0;
      hi_q     <= 16'd0;
      lo_q     <= 16'd0;
    end else begin
      rd_en_q  <= fetch_i | (rd_en_q & ~second_q);
      second_q <= rd_en_q & ~second_q;
      dv_q     <= rd_en_q;
      dsel_q   <= second_q;
      if (dv_q && !dsel_q) begin
        hi_q <= rd_data_i;
      end
      if (dv_q && dsel_q) begin
        lo_q <= rd_data_i;
      end
      if (fetch_i) begin
        valid_q <= 1'b0;
      end else if (dv_q && dsel_q) begin
        valid_q <= 1'b1;
      end
    end
  end

  assign rd_en_o = rd_en_q;
  assign word_o  = {hi_q, lo_q};
  assign valid_o = valid_q;

endmodule

// File: rtl/sdram_udp_tx.sv
// Reads one RGB565 frame from the SDRAM read FIFO and feeds it to the UDP
// transmitter as header-prefixed packets of packed pixel pairs.
module sdram_udp_tx
  import sdram_udp_tx_pkg::*;
#(
  parameter int H_PIXEL    = DEF_H_PIXEL,
  parameter int V_PIXEL    = DEF_V_PIXEL,
  parameter int PKT_PIXELS = DEF_PKT_PIXELS,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic        eth_tx_clk,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  output logic        rd_en,
  input  logic [15:0] rd_data,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  input  logic        tx_req,
  output logic [31:0] tx_data,
  input  logic        tx_done
);

  localparam logic [19:0] FRAME_PIX = 20'(H_PIXEL * V_PIXEL);
  localparam logic [10:0] PKT_MAX   = 11'(PKT_PIXELS);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  tx_state_e   state_q;
  logic        busy_q;
  logic        frame_done_q;
  logic        tx_start_en_q;
  logic        fetched_q;
  logic [15:0] tx_byte_num_q;
  logic [15:0] pkt_idx_q;
  logic [15:0] gap_cnt_q;
  logic [31:0] tx_data_q;
  logic [19:0] pix_left_q;
  logic [10:0] pkt_pix_q;
  logic [9:0]  fetch_left_q;
  logic [9:0]  send_left_q;

  logic        fetch_s;
  logic [31:0] next_word_s;
  logic        word_valid_s;

  // Request a word pair on PRELOAD entry and on each served tx_req with pixels still unread.
  always_comb begin
    fetch_s = 1'b0;
    if (state_q == ST_PRELOAD) begin
      fetch_s = !fetched_q;
    end else if (state_q == ST_SEND) begin
      fetch_s = tx_req && !tx_done && (send_left_q != 10'd0) && (fetch_left_q != 10'd0);
    end else begin
      fetch_s = 1'b0;
    end
  end

  px_word_packer u_packer (
    .clk       (eth_tx_clk),
    .rst_n     (rst_n),
    .fetch_i   (fetch_s),
    .rd_data_i (rd_data),
    .rd_en_o   (rd_en),
    .word_o    (next_word_s),
    .valid_o   (word_valid_s)
  );

  // Frame/packet sequencing FSM with counters and registered udp-side outputs.
  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      tx_start_en_q <= 1'b0;
      fetched_q     <= 1'b0;
      tx_byte_num_q <= 16'd0;
      pkt_idx_q     <= 16'd0;
      gap_cnt_q     <= 16'd0;
      tx_data_q     <= 32'd0;
      pix_left_q    <= 20'd0;
      pkt_pix_q     <= 11'd0;
      fetch_left_q  <= 10'd0;
      send_left_q   <= 10'd0;
    end else begin
      tx_start_en_q <= 1'b0;
      frame_done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_start && sdram_init_done) begin
            busy_q     <= 1'b1;
            pix_left_q <= FRAME_PIX;
            pkt_idx_q  <= 16'd0;
            pkt_pix_q  <= pkt_len(FRAME_PIX, PKT_MAX);
            fetched_q  <= 1'b0;
            state_q    <= ST_PRELOAD;
          end
        end
        ST_PRELOAD: begin
          if (!fetched_q) begin
            fetched_q    <= 1'b1;
            fetch_left_q <= pkt_pix_q[10:1] - 10'd1;
          end else if (word_valid_s) begin
            state_q <= ST_START;
          end
        end
        ST_START: begin
          tx_data_q     <= hdr_word(pkt_idx_q);
          tx_byte_num_q <= 16'd4 + {4'd0, pkt_pix_q, 1'b0};
          tx_start_en_q <= 1'b1;
          send_left_q   <= pkt_pix_q[10:1];
          state_q       <= ST_SEND;
        end
        ST_SEND, ST_WAIT_DONE: begin
          if (tx_done) begin
            pix_left_q <= pix_left_q - {9'd0, pkt_pix_q};
            pkt_idx_q  <= pkt_idx_q + 16'd1;
            if (pix_left_q == {9'd0, pkt_pix_q}) begin
              frame_done_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= ST_IDLE;
            end else begin
              gap_cnt_q <= 16'd0;
              state_q   <= ST_GAP;
            end
          end else if (tx_req && (send_left_q != 10'd0)) begin
            // Requests past the packet's last word fall through here untouched.
            tx_data_q   <= next_word_s;
            send_left_q <= send_left_q - 10'd1;
            if (fetch_left_q != 10'd0) begin
              fetch_left_q <= fetch_left_q - 10'd1;
            end
            if (send_left_q == 10'd1) begin
              state_q <= ST_WAIT_DONE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q >= GAP_LAST) begin
            gap_cnt_q <= 16'd0;
            pkt_pix_q <= pkt_len(pix_left_q, PKT_MAX);
            fetched_q <= 1'b0;
            state_q   <= ST_PRELOAD;
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign tx_start_en = tx_start_en_q;
  assign tx_byte_num = tx_byte_num_q;
  assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_sdram_udp_tx.sv
// Self-checking bench for sdram_udp_tx on a 10x3 frame with 8-pixel packets,
// driving an SDRAM read-FIFO model and a udp handshake model.
module tb_sdram_udp_tx;

  localparam int H     = 10;
  localparam int V     = 3;
  localparam int PKT   = 8;
  localparam int GAP   = 4;
  localparam int FRAME = H * V;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sdram_init_done;
  logic        frame_start;
  logic        busy;
  logic        frame_done;
  logic        rd_en;
  logic [15:0] rd_data = 16'd0;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req;
  logic [31:0] tx_data;
  logic        tx_done;

  logic [15:0] mem [0:FRAME-1];
  logic        fifo_load;
  int          rd_ptr = 0;
  int          rd_count = 0;
  int          start_count = 0;
  int          vectors = 0;
  int          miscompares = 0;

  sdram_udp_tx #(
    .H_PIXEL    (H),
    .V_PIXEL    (V),
    .PKT_PIXELS (PKT),
    .GAP_CYCLES (GAP)
  ) dut (
    .eth_tx_clk      (clk),
    .rst_n           (rst_n),
    .sdram_init_done (sdram_init_done),
    .frame_start     (frame_start),
    .busy            (busy),
    .frame_done      (frame_done),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .tx_start_en     (tx_start_en),
    .tx_byte_num     (tx_byte_num),
    .tx_req          (tx_req),
    .tx_data         (tx_data),
    .tx_done         (tx_done)
  );

  always #5 clk = ~clk;

  // Read FIFO model: data appears the cycle after rd_en; also counts reads and packet starts.
  always @(posedge clk) begin
    if (fifo_load) begin
      rd_ptr      <= 0;
      rd_count    <= 0;
      start_count <= 0;
    end else begin
      if (rd_en) begin
        rd_data  <= (rd_ptr < FRAME) ? mem[rd_ptr] : 16'hDEAD;
        rd_ptr   <= rd_ptr + 1;
        rd_count <= rd_count + 1;
      end
      if (tx_start_en) begin
        start_count <= start_count + 1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string where);
    chk({where, "_busy"},        32'(busy),        32'd0);
    chk({where, "_frame_done"},  32'(frame_done),  32'd0);
    chk({where, "_rd_en"},       32'(rd_en),       32'd0);
    chk({where, "_tx_start_en"}, 32'(tx_start_en), 32'd0);
    chk({where, "_tx_byte_num"}, 32'(tx_byte_num), 32'd0);
    chk({where, "_tx_data"},     tx_data,          32'd0);
  endtask

  task automatic wait_start(output int t, output bit seen);
    seen = 1'b0;
    t = 0;
    while (!seen && t < 400) begin
      @(negedge clk);
      t++;
      if (tx_start_en) seen = 1'b1;
    end
  endtask

  task automatic req_word();
    @(negedge clk); tx_req = 1'b1;
    @(negedge clk); tx_req = 1'b0;
  endtask

  task automatic run_packet(input int idx, input int npix, input int base, input bit extra,
                            input bit dup_start, input bit last, output bit ok);
    int t;
    bit seen;
    logic [31:0] held;
    int cnt;
    wait_start(t, seen);
    chk("start_seen", 32'(seen), 32'd1);
    ok = seen;
    if (!seen) return;
    if (idx > 0) chk("gap_len", 32'(t > GAP), 32'd1);
    chk("header", tx_data, 32'hA55A0000 | 32'(idx));
    chk("byte_num", 32'(tx_byte_num), 32'(4 + 2 * npix));
    for (int w = 0; w < npix / 2; w++) begin
      req_word();
      chk("data_word", tx_data, {mem[base + 2 * w], mem[base + 2 * w + 1]});
      if (dup_start && w == 0) begin
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
      end
      repeat (6) @(negedge clk);
    end
    chk("reads_so_far", 32'(rd_count), 32'(base + npix));
    if (extra) begin
      held = tx_data;
      cnt = rd_count;
      req_word();
      repeat (4) @(negedge clk);
      chk("extra_req_data", tx_data, held);
      chk("extra_req_reads", 32'(rd_count), 32'(cnt));
    end
    chk("byte_num_stable", 32'(tx_byte_num), 32'(4 + 2 * npix));
    @(negedge clk); tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
    chk("frame_done_pulse", 32'(frame_done), 32'(last));
    chk("busy_after_pkt", 32'(busy), 32'(!last));
    if (last) begin
      @(negedge clk);
      chk("frame_done_clear", 32'(frame_done), 32'd0);
    end
  endtask

  task automatic run_frame(input bit extra, input bit dup);
    int remaining;
    int base;
    int idx;
    int npix;
    bit ok;
    @(negedge clk); fifo_load = 1'b1;
    @(negedge clk); fifo_load = 1'b0;
    frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    remaining = FRAME;
    base = 0;
    idx = 0;
    ok = 1'b1;
    while (remaining > 0 && ok) begin
      npix = (remaining < PKT) ? remaining : PKT;
      run_packet(idx, npix, base, extra && idx == 1, dup && idx == 0, remaining == npix, ok);
      base += npix;
      remaining -= npix;
      idx++;
    end
    repeat (4) @(negedge clk);
    chk("packets_per_frame", 32'(start_count), 32'((FRAME + PKT - 1) / PKT));
    chk("reads_per_frame", 32'(rd_count), 32'(FRAME));
  endtask

  initial begin
    int t;
    bit seen;
    rst_n = 1'b0;
    sdram_init_done = 1'b0;
    frame_start = 1'b0;
    tx_req = 1'b0;
    tx_done = 1'b0;
    fifo_load = 1'b1;
    for (int i = 0; i < FRAME; i++) mem[i] = 16'(i);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    fifo_load = 1'b0;

    frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("noinit_reads", 32'(rd_count), 32'd0);
    chk("noinit_starts", 32'(start_count), 32'd0);
    chk("noinit_busy", 32'(busy), 32'd0);

    sdram_init_done = 1'b1;
    run_frame(1'b1, 1'b1);

    for (int i = 0; i < FRAME; i++) mem[i] = 16'($urandom);
    run_frame(1'b0, 1'b0);

    for (int i = 0; i < FRAME; i++) mem[i] = 16'($urandom);
    @(negedge clk); fifo_load = 1'b1;
    @(negedge clk); fifo_load = 1'b0;
    frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    wait_start(t, seen);
    chk("midrst_start", 32'(seen), 32'd1);
    for (int w = 0; w < 2; w++) begin
      req_word();
      repeat (6) @(negedge clk);
    end
    chk("midrst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < FRAME; i++) mem[i] = 16'($urandom);
    run_frame(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
